// File: rtl/sqrt_pkg.sv
// Shared encodings for the integer square-root controller: FSM states,
// datapath ALU opcodes and register-file slot assignments.
package sqrt_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_LD_N     = 4'd1;
  localparam state_t S_LD_R1    = 4'd2;
  localparam state_t S_LD_R3    = 4'd3;
  localparam state_t S_LD_R2    = 4'd4;
  localparam state_t S_LD_R4    = 4'd5;
  localparam state_t S_SUB      = 4'd6;
  localparam state_t S_INC      = 4'd7;
  localparam state_t S_ODD      = 4'd8;
  localparam state_t S_INC_LAST = 4'd9;
  localparam state_t S_OUT      = 4'd10;
  localparam state_t S_DONE     = 4'd11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam int REG_REM  = 0;
  localparam int REG_ODD  = 1;
  localparam int REG_ROOT = 2;
  localparam int REG_ONE  = 3;
  localparam int REG_TWO  = 4;

endpackage

// File: rtl/sqrt_ctrl.sv
// Sequencer for the shared datapath computing floor(sqrt(N)) by repeatedly
// subtracting successive odd numbers; root is read back in OUT and registered.
//
// state    | meaning
// IDLE     | waiting for start_i
// LD_N     | R0 <- operand_i
// LD_R1    | R1 <- 1 (first odd number)
// LD_R3    | R3 <- 1
// LD_R2    | R2 <- 0 (root accumulator)
// LD_R4    | R4 <- 2 (odd-number step)
// SUB      | R0 <- R0 - R1, branch on flags
// INC      | R2 <- R2 + 1
// ODD      | R1 <- R1 + 2
// INC_LAST | R2 <- R2 + 1, remainder hit exactly zero
// OUT      | read R2 onto data_o, capture into result
// DONE     | done_o pulse
module sqrt_ctrl
  import sqrt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [DATA_WIDTH-1:0] dp_data_o,
  output logic                  IE,
  output logic                  WE,
  output logic                  OE,
  output logic [ADDR_WIDTH-1:0] ADDR_WR,
  output logic [ADDR_WIDTH-1:0] ADDR_RDA,
  output logic [ADDR_WIDTH-1:0] ADDR_RDB,
  output logic [1:0]            ALU_Op,
  input  logic [DATA_WIDTH-1:0] dp_data_i,
  input  logic                  negative_i,
  input  logic                  zero_i
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      S_IDLE:     if (start_i) state_d = S_LD_N;
      S_LD_N:     state_d = S_LD_R1;
      S_LD_R1:    state_d = S_LD_R3;
      S_LD_R3:    state_d = S_LD_R2;
      S_LD_R2:    state_d = S_LD_R4;
      S_LD_R4:    state_d = S_SUB;
      S_SUB: begin
        // A negative remainder means the last odd number overshot: root is final.
        if (negative_i)  state_d = S_OUT;
        else if (zero_i) state_d = S_INC_LAST;
        else             state_d = S_INC;
      end
      S_INC:      state_d = S_ODD;
      S_ODD:      state_d = S_SUB;
      S_INC_LAST: state_d = S_OUT;
      S_OUT: begin
        result_d = dp_data_i;
        state_d  = S_DONE;
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    IE        = 1'b0;
    WE        = 1'b0;
    OE        = 1'b0;
    ADDR_WR   = '0;
    ADDR_RDA  = '0;
    ADDR_RDB  = '0;
    ALU_Op    = 2'b00;
    dp_data_o = '0;
    case (state_q)
      S_LD_N: begin
        IE = 1'b1; WE = 1'b1;
        ADDR_WR   = ADDR_WIDTH'(REG_REM);
        dp_data_o = operand_i;
      end
      S_LD_R1: begin
        IE = 1'b1; WE = 1'b1;
        ADDR_WR   = ADDR_WIDTH'(REG_ODD);
        dp_data_o = DATA_WIDTH'(1);
      end
      S_LD_R3: begin
        IE = 1'b1; WE = 1'b1;
        ADDR_WR   = ADDR_WIDTH'(REG_ONE);
        dp_data_o = DATA_WIDTH'(1);
      end
      S_LD_R2: begin
        IE = 1'b1; WE = 1'b1;
        ADDR_WR   = ADDR_WIDTH'(REG_ROOT);
      end
      S_LD_R4: begin
        IE = 1'b1; WE = 1'b1;
        ADDR_WR   = ADDR_WIDTH'(REG_TWO);
        dp_data_o = DATA_WIDTH'(2);
      end
      S_SUB: begin
        WE = 1'b1;
        ADDR_WR  = ADDR_WIDTH'(REG_REM);
        ADDR_RDA = ADDR_WIDTH'(REG_REM);
        ADDR_RDB = ADDR_WIDTH'(REG_ODD);
        ALU_Op   = ALU_SUB;
      end
      S_INC, S_INC_LAST: begin
        WE = 1'b1;
        ADDR_WR  = ADDR_WIDTH'(REG_ROOT);
        ADDR_RDA = ADDR_WIDTH'(REG_ROOT);
        ADDR_RDB = ADDR_WIDTH'(REG_ONE);
        ALU_Op   = ALU_ADD;
      end
      S_ODD: begin
        WE = 1'b1;
        ADDR_WR  = ADDR_WIDTH'(REG_ODD);
        ADDR_RDA = ADDR_WIDTH'(REG_ODD);
        ADDR_RDB = ADDR_WIDTH'(REG_TWO);
        ALU_Op   = ALU_ADD;
      end
      S_OUT: begin
        OE = 1'b1;
        ADDR_RDA = ADDR_WIDTH'(REG_ROOT);
        ALU_Op   = ALU_PASS;
      end
      default: ;
    endcase
  end

  assign busy_o   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: doc/sqrt_ctrl.md
Name: sqrt_ctrl

Overview:
- Control FSM that drives the `datapath` block: 8-entry register file, 2-bit ALU, `negative_o`/`zero_o` flags.
- It is the driving end of that interface. It sequences `IE`, `WE`, `OE`, the three addresses and `ALU_Op`, and supplies the datapath `data_i`.
- It consumes the datapath status flags and `data_o`.
- It computes floor(sqrt(N)) of an unsigned operand by odd-number subtraction. It is the integer pre-stage of the FP square-root unit.

Parameters:
- DATA_WIDTH, 32, datapath word width.
- ADDR_WIDTH, 3, register-file address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request; sampled in IDLE only.
- operand_i  in  DATA_WIDTH  N; MSB must be 0.
- busy_o  out  1  high from the accepting edge until done_o.
- done_o  out  1  one-cycle pulse; result_o valid.
- result_o  out  DATA_WIDTH  floor(sqrt(N)); held until the next done_o.
- dp_data_o  out  DATA_WIDTH  to datapath `data_i`.
- IE, WE, OE  out  1 each  datapath controls.
- ADDR_WR, ADDR_RDA, ADDR_RDB  out  ADDR_WIDTH each  datapath addresses.
- ALU_Op  out  2  datapath ALU opcode.
- dp_data_i  in  DATA_WIDTH  from datapath `data_o`.
- negative_i, zero_i  in  1 each  from datapath `negative_o`/`zero_o`.

Behaviour:
- Datapath contract:
  - Write occurs at the rising clk edge when WE=1.
  - Write data is dp_data_o if IE=1, else the ALU result.
  - ALU_Op encoding: 00 ADD A+B, 01 SUB A-B, 10 AND, 11 PASS A.
  - Flags are combinational from the ALU result. data_o equals the ALU result when OE=1.
- Register map: R0 = remainder (N); R1 = current odd; R2 = root; R3 = constant 1; R4 = constant 2.
- Control outputs are Moore-decoded from state. All controls and dp_data_o are 0 in IDLE and DONE.
- States and transitions:
  - IDLE: start_i=1 → LD_N; busy_o rises after the edge.
  - LD_N: IE=WE=1, ADDR_WR=0, dp_data_o=operand_i → LD_R1.
  - LD_R1: write 1 to R1 → LD_R3.
  - LD_R3: write 1 to R3 → LD_R2.
  - LD_R2: write 0 to R2 → LD_R4.
  - LD_R4: write 2 to R4 → SUB.
  - SUB: WE=1, ADDR_WR=0, RDA=0, RDB=1, ALU_Op=01. Flags are sampled this cycle: negative_i → OUT; else zero_i → INC_LAST; else → INC.
  - INC: R2 = R2 + R3 → ODD.
  - ODD: R1 = R1 + R4 → SUB.
  - INC_LAST: R2 = R2 + R3 → OUT.
  - OUT: OE=1, RDA=2, ALU_Op=11. At the leaving edge, result_o ← dp_data_i and done_o ← 1 → DONE.
  - DONE: done_o high for this single cycle, busy_o low → IDLE.
- Latency (edge sampling start_i to the cycle with done_o=1), s = floor(sqrt N):
  - Non-square: 7 + 3s.
  - Perfect square with s≥1: 5 + 3s.
  - N=0: 7.
- Boundaries:
  - start_i while busy or in DONE is ignored, with no queueing.
  - A negative SUB corrupts R0; this is harmless because R0 is reloaded on every start.
  - Operand MSB=1 is out of range: result undefined, but the FSM must still terminate (by design it cannot hang).
- Reset (asynchronous, any state, including mid-loop):
  - state=IDLE; busy_o=done_o=0; result_o=0; all datapath controls 0.
  - No partial write is issued after reset asserts.

Decomposition:
- Shared package `sqrt_pkg` holds:
  - state enum;
  - ALU_Op constants ALU_ADD/SUB/AND/PASS;
  - register index constants REG_REM, REG_ODD, REG_ROOT, REG_ONE, REG_TWO.
- No sub-module. Single FSM with a registered result.
- The top-level pairing of sqrt_ctrl with datapath lives in its own wrapper.

Test Plan:
- N=4: start pulse → done_o 11 cycles later, result_o=2, busy_o high throughout.
- N=0 → done_o after 7 cycles, result_o=0.
- N=8 → 13 cycles, result_o=2. N=1 → 8 cycles, result_o=1. N=2 → 10 cycles, result_o=1.
- N=1000000 → result_o=1000 after 3005 cycles; start_i re-pulsed mid-run → ignored, single done_o.
- rst_n low for 1 cycle during the ODD state of N=100 → all outputs 0 immediately; a new start with N=9 → result_o=3 after 14 cycles.
- Back-to-back: start_i held high → second run begins in the cycle after DONE; each done_o is exactly 1 cycle wide.
